// File: rtl/rs422_test_pkg.sv
// Shared constants and state encoding for the RS422 loopback test sequencer.
package rs422_test_pkg;

    // RX channels checked per pattern
    localparam int unsigned NUM_RX = 9;

    // Slave register map (only bits [7:0] of the address are significant)
    localparam logic [7:0] REG_PATTERN   = 8'h00;
    localparam logic [7:0] REG_LEN       = 8'h01;
    localparam logic [7:0] REG_TX_CTRL   = 8'h02;
    localparam logic [7:0] REG_RX_STATUS = 8'h03;
    localparam logic [7:0] REG_ERR_BASE  = 8'h0D;

    // TX_CTRL bit positions and the one-hot words written to it
    localparam int unsigned TX_START_BIT = 0;
    localparam int unsigned TX_STOP_BIT  = 1;
    localparam int unsigned TX_CLEAR_BIT = 2;
    localparam logic [31:0] TX_CTRL_START = 32'h1 << TX_START_BIT;
    localparam logic [31:0] TX_CTRL_STOP  = 32'h1 << TX_STOP_BIT;
    localparam logic [31:0] TX_CTRL_CLEAR = 32'h1 << TX_CLEAR_BIT;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WR_PAT     = 4'd1,
        S_WR_LEN     = 4'd2,
        S_CLR        = 4'd3,
        S_GO         = 4'd4,
        S_WAIT       = 4'd5,
        S_RD_STAT    = 4'd6,
        S_CAP_STAT   = 4'd7,
        S_STOP       = 4'd8,
        S_RD_ERR     = 4'd9,
        S_CAP_ERR    = 4'd10,
        S_NEXT       = 4'd11,
        S_DONE       = 4'd12,
        S_ABORT_STOP = 4'd13,
        S_ABORT_CLR  = 4'd14
    } seq_state_t;

endpackage

// File: rtl/rs422_seq_poll_timer.sv
// Poll pacing: interval countdown while waiting, plus per-pattern status-read counter.
module rs422_seq_poll_timer #(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned TIMEOUT_POLLS = 4096
) (
    input  logic OPB_CLK,
    input  logic OPB_RST,
    input  logic wait_active,
    input  logic poll_inc,
    input  logic poll_clr,
    output logic interval_done_c,
    output logic poll_last_c
);

    localparam int unsigned IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);

    logic [IW-1:0] interval_cnt;
    logic [PW-1:0] poll_cnt;

    // Reload outside WAIT so every WAIT visit lasts exactly POLL_INTERVAL cycles
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            interval_cnt <= '0;
        end else if (!wait_active) begin
            interval_cnt <= IW'(POLL_INTERVAL - 1);
        end else if (interval_cnt != '0) begin
            interval_cnt <= interval_cnt - IW'(1);
        end
    end

    // Status reads issued for the current pattern
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            poll_cnt <= '0;
        end else if (poll_clr) begin
            poll_cnt <= '0;
        end else if (poll_inc) begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    assign interval_done_c = (interval_cnt == '0);
    // The read being evaluated now is the last one allowed
    assign poll_last_c     = (poll_cnt == PW'(TIMEOUT_POLLS - 1));

endmodule

// File: rtl/rs422_test_sequencer.sv
// Autonomous multi-pattern RS422 loopback test run acting as a second register master.
module rs422_test_sequencer
    import rs422_test_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS      = 4,
    parameter logic [31:0] PATTERN_LIST      = 32'hFF00AA55,
    parameter int unsigned BYTES_PER_PATTERN = 256,
    parameter int unsigned POLL_INTERVAL     = 1024,
    parameter int unsigned TIMEOUT_POLLS     = 4096
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST,
    input  logic              SEQ_START,
    input  logic              SEQ_ABORT,
    output logic              SEQ_BUSY,
    output logic              SEQ_DONE,
    output logic              SEQ_PASS,
    output logic              SEQ_TIMEOUT,
    output logic [NUM_RX-1:0] CHAN_FAIL,
    output logic [31:0]       ERR_TOTAL,
    output logic [1:0]        CUR_PATTERN,
    output logic [31:0]       M_ADDR,
    output logic [31:0]       M_DI,
    output logic              M_WE,
    output logic              M_RE,
    input  logic [31:0]       M_DO
);

    seq_state_t  state;
    logic [3:0]  err_idx;
    logic        aborted;
    logic        interval_done_c;
    logic        poll_last_c;
    logic        wait_active_c;
    logic        poll_inc_c;
    logic        poll_clr_c;
    logic        stat_ok_c;
    logic        abort_req_c;
    logic [32:0] err_sum_c;

    function automatic logic [7:0] pat_byte(input logic [1:0] k);
        return 8'(PATTERN_LIST >> {k, 3'b000});
    endfunction

    assign stat_ok_c     = M_DO[0] & (&M_DO[9:1]);
    assign abort_req_c   = SEQ_ABORT && (state != S_IDLE) && (state != S_DONE) &&
                           (state != S_ABORT_STOP) && (state != S_ABORT_CLR);
    assign err_sum_c     = {1'b0, ERR_TOTAL} + {1'b0, M_DO};
    assign wait_active_c = (state == S_WAIT);
    assign poll_inc_c    = (state == S_CAP_STAT) && !SEQ_ABORT && !stat_ok_c;
    assign poll_clr_c    = (state == S_IDLE) || (state == S_NEXT);

    rs422_seq_poll_timer #(
        .POLL_INTERVAL (POLL_INTERVAL),
        .TIMEOUT_POLLS (TIMEOUT_POLLS)
    ) u_poll_timer (
        .OPB_CLK         (OPB_CLK),
        .OPB_RST         (OPB_RST),
        .wait_active     (wait_active_c),
        .poll_inc        (poll_inc_c),
        .poll_clr        (poll_clr_c),
        .interval_done_c (interval_done_c),
        .poll_last_c     (poll_last_c)
    );

    // Sequencer FSM; bus strobes are registered so they coincide with their state
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state       <= S_IDLE;
            err_idx     <= '0;
            aborted     <= 1'b0;
            SEQ_BUSY    <= 1'b0;
            SEQ_DONE    <= 1'b0;
            SEQ_PASS    <= 1'b0;
            SEQ_TIMEOUT <= 1'b0;
            CHAN_FAIL   <= '0;
            ERR_TOTAL   <= '0;
            CUR_PATTERN <= '0;
            M_ADDR      <= '0;
            M_DI        <= '0;
            M_WE        <= 1'b0;
            M_RE        <= 1'b0;
        end else begin
            M_WE     <= 1'b0;
            M_RE     <= 1'b0;
            M_ADDR   <= '0;
            M_DI     <= '0;
            SEQ_DONE <= 1'b0;
            if (abort_req_c) begin
                // Any pending capture is dropped by leaving the CAP state here
                state   <= S_ABORT_STOP;
                aborted <= 1'b1;
                M_WE    <= 1'b1;
                M_ADDR  <= 32'(REG_TX_CTRL);
                M_DI    <= TX_CTRL_STOP;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (SEQ_START && !SEQ_ABORT) begin
                            state       <= S_WR_PAT;
                            SEQ_BUSY    <= 1'b1;
                            SEQ_PASS    <= 1'b0;
                            SEQ_TIMEOUT <= 1'b0;
                            CHAN_FAIL   <= '0;
                            ERR_TOTAL   <= '0;
                            CUR_PATTERN <= '0;
                            aborted     <= 1'b0;
                            M_WE        <= 1'b1;
                            M_ADDR      <= 32'(REG_PATTERN);
                            M_DI        <= 32'(pat_byte(2'd0));
                        end
                    end
                    S_WR_PAT: begin
                        state  <= S_WR_LEN;
                        M_WE   <= 1'b1;
                        M_ADDR <= 32'(REG_LEN);
                        M_DI   <= 32'(BYTES_PER_PATTERN);
                    end
                    S_WR_LEN: begin
                        state  <= S_CLR;
                        M_WE   <= 1'b1;
                        M_ADDR <= 32'(REG_TX_CTRL);
                        M_DI   <= TX_CTRL_CLEAR;
                    end
                    S_CLR: begin
                        state  <= S_GO;
                        M_WE   <= 1'b1;
                        M_ADDR <= 32'(REG_TX_CTRL);
                        M_DI   <= TX_CTRL_START;
                    end
                    S_GO: state <= S_WAIT;
                    S_WAIT: begin
                        if (interval_done_c) begin
                            state  <= S_RD_STAT;
                            M_RE   <= 1'b1;
                            M_ADDR <= 32'(REG_RX_STATUS);
                        end
                    end
                    S_RD_STAT: state <= S_CAP_STAT;
                    S_CAP_STAT: begin
                        if (stat_ok_c) begin
                            state   <= S_RD_ERR;
                            err_idx <= '0;
                            M_RE    <= 1'b1;
                            M_ADDR  <= 32'(REG_ERR_BASE);
                        end else if (poll_last_c) begin
                            state       <= S_STOP;
                            SEQ_TIMEOUT <= 1'b1;
                            CHAN_FAIL   <= CHAN_FAIL | ~M_DO[9:1];
                            M_WE        <= 1'b1;
                            M_ADDR      <= 32'(REG_TX_CTRL);
                            M_DI        <= TX_CTRL_STOP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_STOP: begin
                        state   <= S_RD_ERR;
                        err_idx <= '0;
                        M_RE    <= 1'b1;
                        M_ADDR  <= 32'(REG_ERR_BASE);
                    end
                    S_RD_ERR: state <= S_CAP_ERR;
                    S_CAP_ERR: begin
                        if (M_DO != '0) begin
                            CHAN_FAIL[err_idx] <= 1'b1;
                        end
                        ERR_TOTAL <= err_sum_c[32] ? 32'hFFFF_FFFF : err_sum_c[31:0];
                        if (err_idx == 4'(NUM_RX - 1)) begin
                            state <= S_NEXT;
                        end else begin
                            state   <= S_RD_ERR;
                            err_idx <= err_idx + 4'd1;
                            M_RE    <= 1'b1;
                            M_ADDR  <= 32'(REG_ERR_BASE + 8'(err_idx) + 8'd1);
                        end
                    end
                    S_NEXT: begin
                        if (CUR_PATTERN == 2'(NUM_PATTERNS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            state       <= S_WR_PAT;
                            CUR_PATTERN <= CUR_PATTERN + 2'd1;
                            M_WE        <= 1'b1;
                            M_ADDR      <= 32'(REG_PATTERN);
                            M_DI        <= 32'(pat_byte(CUR_PATTERN + 2'd1));
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        SEQ_DONE <= 1'b1;
                        SEQ_BUSY <= 1'b0;
                        SEQ_PASS <= (CHAN_FAIL == '0) && !SEQ_TIMEOUT && !aborted;
                    end
                    S_ABORT_STOP: begin
                        state  <= S_ABORT_CLR;
                        M_WE   <= 1'b1;
                        M_ADDR <= 32'(REG_TX_CTRL);
                        M_DI   <= TX_CTRL_CLEAR;
                    end
                    S_ABORT_CLR: state <= S_DONE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rs422_test_sequencer.sv
// Randomized bench for rs422_test_sequencer against a loopback slave and a run-level model.
module tb_rs422_test_sequencer;
    import rs422_test_pkg::*;

    localparam int unsigned NPAT   = 2;
    localparam logic [31:0] PLIST  = 32'hFF00AA55;
    localparam int unsigned BPP    = 4;
    localparam int unsigned PI     = 8;
    localparam int unsigned TPOLLS = 3;

    logic              OPB_CLK = 1'b0;
    logic              OPB_RST = 1'b1;
    logic              SEQ_START = 1'b0;
    logic              SEQ_ABORT = 1'b0;
    logic              SEQ_BUSY, SEQ_DONE, SEQ_PASS, SEQ_TIMEOUT;
    logic [NUM_RX-1:0] CHAN_FAIL;
    logic [31:0]       ERR_TOTAL;
    logic [1:0]        CUR_PATTERN;
    logic [31:0]       M_ADDR, M_DI;
    logic              M_WE, M_RE;
    logic [31:0]       M_DO = 32'h0;

    rs422_test_sequencer #(
        .NUM_PATTERNS      (NPAT),
        .PATTERN_LIST      (PLIST),
        .BYTES_PER_PATTERN (BPP),
        .POLL_INTERVAL     (PI),
        .TIMEOUT_POLLS     (TPOLLS)
    ) dut (
        .OPB_CLK     (OPB_CLK),
        .OPB_RST     (OPB_RST),
        .SEQ_START   (SEQ_START),
        .SEQ_ABORT   (SEQ_ABORT),
        .SEQ_BUSY    (SEQ_BUSY),
        .SEQ_DONE    (SEQ_DONE),
        .SEQ_PASS    (SEQ_PASS),
        .SEQ_TIMEOUT (SEQ_TIMEOUT),
        .CHAN_FAIL   (CHAN_FAIL),
        .ERR_TOTAL   (ERR_TOTAL),
        .CUR_PATTERN (CUR_PATTERN),
        .M_ADDR      (M_ADDR),
        .M_DI        (M_DI),
        .M_WE        (M_WE),
        .M_RE        (M_RE),
        .M_DO        (M_DO)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int checks = 0;
    int errors = 0;

    // Slave configuration for the current run
    int unsigned ready_after [NPAT];   // status reads returning stuck_val before all-ones
    logic [9:0]  stuck_val   [NPAT];
    logic [31:0] err_tab     [NPAT][NUM_RX];

    // Slave-side observation
    logic [39:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int bus_viol   = 0;
    int pat_cnt    = 0;
    int pat_idx    = 0;
    int stat_reads = 0;

    // Expected outcome of a run
    logic [39:0]       exp_wr [$];
    logic [7:0]        exp_rd [$];
    logic [NUM_RX-1:0] exp_fail;
    logic [31:0]       exp_tot;
    logic              exp_to;
    logic              exp_pass;
    int                exp_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loopback register slave: logs traffic, checks bus rules, answers reads
    always @(negedge OPB_CLK) begin
        if (OPB_RST) begin
            M_DO       = 32'h0;
            stat_reads = 0;
            pat_idx    = 0;
        end else begin
            if (M_WE && M_RE) bus_viol++;
            if (!M_WE && !M_RE && (M_ADDR != 32'h0 || M_DI != 32'h0)) bus_viol++;
            if (M_ADDR[31:8] != 24'h0) bus_viol++;
            if (M_RE && M_DI != 32'h0) bus_viol++;
            if (M_WE) begin
                wr_log.push_back({M_ADDR[7:0], M_DI});
                if (M_ADDR[7:0] == 8'h00) begin
                    pat_idx = (pat_cnt < int'(NPAT)) ? pat_cnt : int'(NPAT) - 1;
                    pat_cnt++;
                end
                if (M_ADDR[7:0] == 8'h02 && M_DI[2]) stat_reads = 0;
            end
            if (M_RE) begin
                int n;
                rd_log.push_back(M_ADDR[7:0]);
                n = int'(M_ADDR[7:0]) - 13;
                if (M_ADDR[7:0] == 8'h03) begin
                    M_DO = (stat_reads < int'(ready_after[pat_idx])) ?
                           {22'h0, stuck_val[pat_idx]} : 32'h3FF;
                    stat_reads++;
                end else if (n >= 0 && n < int'(NUM_RX)) begin
                    M_DO = err_tab[pat_idx][n];
                end else begin
                    M_DO = 32'h0;
                end
            end
        end
    end

    // Run-level expectation from the configured slave behaviour
    task automatic build_expect();
        longint unsigned tot = 0;
        exp_wr.delete();
        exp_rd.delete();
        exp_fail = '0;
        exp_to   = 1'b0;
        exp_len  = 0;
        for (int p = 0; p < int'(NPAT); p++) begin
            int  reads;
            logic to;
            exp_wr.push_back({8'h00, (PLIST >> (8 * p)) & 32'hFF});
            exp_wr.push_back({8'h01, BPP});
            exp_wr.push_back({8'h02, 32'h4});
            exp_wr.push_back({8'h02, 32'h1});
            to    = (ready_after[p] >= TPOLLS);
            reads = to ? int'(TPOLLS) : int'(ready_after[p]) + 1;
            for (int r = 0; r < reads; r++) exp_rd.push_back(8'h03);
            if (to) begin
                exp_to   = 1'b1;
                exp_fail = exp_fail | ~stuck_val[p][9:1];
                exp_wr.push_back({8'h02, 32'h2});
            end
            for (int n = 0; n < int'(NUM_RX); n++) begin
                exp_rd.push_back(8'(13 + n));
                if (err_tab[p][n] != 32'h0) exp_fail[n] = 1'b1;
                tot += longint'(err_tab[p][n]);
            end
            exp_len += 4 + reads * (int'(PI) + 2) + (to ? 1 : 0) + 18 + 1;
        end
        exp_tot  = (tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : tot[31:0];
        exp_pass = (exp_fail == '0) && !exp_to;
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(exp_wr[i]));
        chk({tag, "_nrd"}, 64'(rd_log.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), 64'(rd_log[i]), 64'(exp_rd[i]));
        chk({tag, "_busrule"}, 64'(bus_viol), 64'd0);
    endtask

    // Start a run, optionally poke SEQ_START mid-run, wait for SEQ_DONE and check everything
    task automatic run_and_check(input string tag, input int poke);
        int   cyc = 0;
        logic got = 1'b0;
        build_expect();
        wr_log.delete();
        rd_log.delete();
        pat_cnt = 0;
        @(negedge OPB_CLK);
        SEQ_START = 1'b1;
        while (cyc < 3000) begin
            @(negedge OPB_CLK);
            cyc++;
            SEQ_START = (cyc == poke);
            if (SEQ_DONE) begin
                got = 1'b1;
                break;
            end
        end
        SEQ_START = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_len + 2));
        chk({tag, "_pass"}, 64'(SEQ_PASS), 64'(exp_pass));
        chk({tag, "_timeout"}, 64'(SEQ_TIMEOUT), 64'(exp_to));
        chk({tag, "_chan_fail"}, 64'(CHAN_FAIL), 64'(exp_fail));
        chk({tag, "_err_total"}, 64'(ERR_TOTAL), 64'(exp_tot));
        @(negedge OPB_CLK);
        chk({tag, "_done_pulse"}, 64'({SEQ_DONE, SEQ_BUSY}), 64'd0);
        repeat (3) @(negedge OPB_CLK);
        cmp_logs(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({SEQ_BUSY, SEQ_DONE, SEQ_PASS, SEQ_TIMEOUT, CHAN_FAIL,
                                 CUR_PATTERN, M_WE, M_RE}), 64'd0);
        chk({tag, "_total"}, 64'(ERR_TOTAL), 64'd0);
        chk({tag, "_addr"}, 64'(M_ADDR), 64'd0);
        chk({tag, "_di"}, 64'(M_DI), 64'd0);
    endtask

    task automatic clear_cfg();
        for (int p = 0; p < int'(NPAT); p++) begin
            ready_after[p] = 0;
            stuck_val[p]   = 10'h0;
            for (int n = 0; n < int'(NUM_RX); n++) err_tab[p][n] = 32'h0;
        end
    endtask

    initial begin
        int   cyc;
        logic got;

        clear_cfg();
        repeat (3) @(negedge OPB_CLK);
        chk_all_zero("reset");
        OPB_RST = 1'b0;
        repeat (2) @(negedge OPB_CLK);
        chk_all_zero("idle");

        // Clean echo on every channel
        run_and_check("echo", 0);
        chk("echo_pass_const", 64'(SEQ_PASS), 64'd1);

        // RX4 reports 5 errors on both patterns
        clear_cfg();
        err_tab[0][3] = 32'd5;
        err_tab[1][3] = 32'd5;
        run_and_check("rx4err", 0);
        chk("rx4err_mask_const", 64'(CHAN_FAIL), 64'h008);
        chk("rx4err_total_const", 64'(ERR_TOTAL), 64'd10);

        // Pattern 0 status stuck with RX1 missing; SEQ_START while busy must be ignored
        clear_cfg();
        ready_after[0] = 1000;
        stuck_val[0]   = 10'h3FD;
        run_and_check("timeout", 20);
        chk("timeout_flag_const", 64'(SEQ_TIMEOUT), 64'd1);
        chk("timeout_rx1_const", 64'(CHAN_FAIL[0]), 64'd1);

        // Error total saturation
        clear_cfg();
        err_tab[0][0] = 32'hFFFF_FFF0;
        err_tab[1][5] = 32'h20;
        run_and_check("saturate", 0);
        chk("saturate_const", 64'(ERR_TOTAL), 64'hFFFF_FFFF);

        // Abort during WAIT of pattern 0
        clear_cfg();
        wr_log.delete();
        rd_log.delete();
        pat_cnt = 0;
        @(negedge OPB_CLK);
        SEQ_START = 1'b1;
        @(negedge OPB_CLK);
        SEQ_START = 1'b0;
        repeat (5) @(negedge OPB_CLK);
        chk("abort_busy_before", 64'({SEQ_BUSY, CUR_PATTERN}), 64'h4);
        SEQ_ABORT = 1'b1;
        @(negedge OPB_CLK);
        SEQ_ABORT = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 50) begin
            if (SEQ_DONE) begin
                got = 1'b1;
                break;
            end
            @(negedge OPB_CLK);
            cyc++;
        end
        chk("abort_done_seen", 64'(got), 64'd1);
        chk("abort_pass", 64'({SEQ_PASS, SEQ_TIMEOUT}), 64'd0);
        repeat (6) @(negedge OPB_CLK);
        chk("abort_busy_after", 64'(SEQ_BUSY), 64'd0);
        exp_wr.delete();
        exp_rd.delete();
        exp_wr.push_back({8'h00, 32'h55});
        exp_wr.push_back({8'h01, BPP});
        exp_wr.push_back({8'h02, 32'h4});
        exp_wr.push_back({8'h02, 32'h1});
        exp_wr.push_back({8'h02, 32'h2});
        exp_wr.push_back({8'h02, 32'h4});
        cmp_logs("abort");

        // Start and abort together in IDLE: no run
        wr_log.delete();
        SEQ_START = 1'b1;
        SEQ_ABORT = 1'b1;
        @(negedge OPB_CLK);
        SEQ_START = 1'b0;
        SEQ_ABORT = 1'b0;
        repeat (4) @(negedge OPB_CLK);
        chk("start_abort_busy", 64'(SEQ_BUSY), 64'd0);
        chk("start_abort_nwr", 64'(wr_log.size()), 64'd0);

        // Reset asserted during error readback
        clear_cfg();
        err_tab[0][0] = 32'd7;
        pat_cnt = 0;
        @(negedge OPB_CLK);
        SEQ_START = 1'b1;
        @(negedge OPB_CLK);
        SEQ_START = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 500) begin
            if (M_RE && M_ADDR == 32'h0F) begin
                got = 1'b1;
                break;
            end
            @(negedge OPB_CLK);
            cyc++;
        end
        chk("midrst_reached", 64'(got), 64'd1);
        chk("midrst_pre_state", 64'({SEQ_BUSY, CHAN_FAIL}), 64'h201);
        chk("midrst_pre_total", 64'(ERR_TOTAL), 64'd7);
        #2 OPB_RST = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        repeat (2) @(negedge OPB_CLK);
        bus_viol = 0;

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            for (int p = 0; p < int'(NPAT); p++) begin
                int b;
                ready_after[p] = $urandom_range(0, 4);
                stuck_val[p]   = 10'($urandom);
                b              = $urandom_range(0, 9);
                stuck_val[p][b] = 1'b0;
                for (int n = 0; n < int'(NUM_RX); n++) begin
                    case ($urandom_range(0, 5))
                        0, 1, 2: err_tab[p][n] = 32'h0;
                        3, 4:    err_tab[p][n] = 32'($urandom_range(1, 300));
                        default: err_tab[p][n] = $urandom;
                    endcase
                end
            end
            run_and_check($sformatf("rand%0d", it), (it % 2 == 1) ? 30 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
